// File: rtl/regs_pkg.sv
// Shared sizing constants for the register-file writeback scheduler.
package regs_pkg;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREGS     = 64;
  localparam int unsigned REG_IDX_W = 6;
  localparam int unsigned RD_PORT_W = 9;
  localparam int unsigned NUM_SRC   = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned NumSrc = regs_pkg::NUM_SRC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumSrc-1:0] req_i,
  output logic [NumSrc-1:0] grant_o
);
  localparam int unsigned IdxW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    logic [IdxW-1:0] idx_w;
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int unsigned off = 0; off < NumSrc; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NumSrc) idx = idx - NumSrc;
      idx_w = IdxW'(idx);
      if (!found && req_i[idx_w]) begin
        found          = 1'b1;
        grant_o[idx_w] = 1'b1;
        ptr_d          = (idx_w == IdxW'(NumSrc - 1)) ? '0 : idx_w + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regs_wb_sched.sv
// Writeback scheduler and busy-bit scoreboard in front of the 64 x 64-bit register file.
module regs_wb_sched #(
  parameter int unsigned NUM_SRC = regs_pkg::NUM_SRC,
  parameter int unsigned XLEN    = regs_pkg::XLEN,
  parameter int unsigned NREGS   = regs_pkg::NREGS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    issue_valid,
  input  logic [regs_pkg::REG_IDX_W-1:0]          issue_rs1,
  input  logic [regs_pkg::REG_IDX_W-1:0]          issue_rs2,
  input  logic [regs_pkg::REG_IDX_W-1:0]          issue_rd,
  input  logic                                    issue_rd_write,
  output logic                                    issue_ready,
  output logic                                    stall_out,
  input  logic [NUM_SRC-1:0]                      wb_valid,
  input  logic [NUM_SRC*regs_pkg::REG_IDX_W-1:0]  wb_rd,
  input  logic [NUM_SRC*XLEN-1:0]                 wb_value,
  output logic [NUM_SRC-1:0]                      wb_ready,
  output logic [regs_pkg::RD_PORT_W-1:0]          rd_out,
  output logic                                    rd_write_out,
  output logic [XLEN-1:0]                         rd_value_out,
  output logic                                    idle_out,
  output logic                                    err_out
);
  import regs_pkg::*;

  logic [NREGS-1:0]     busy_q, busy_d;
  logic                 wr_q, wr_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      val_q, val_d;
  logic                 err_q, err_d;

  logic [NUM_SRC-1:0]   grant;
  logic                 gnt_valid;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_val;
  logic                 set_en;

  // Requests are masked during reset so no grant is visible while rst is high.
  rr_arbiter #(
    .NumSrc (NUM_SRC)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (wb_valid & {NUM_SRC{~rst}}),
    .grant_o (grant)
  );

  assign wb_ready  = grant;
  assign gnt_valid = |grant;

  always_comb begin
    sel_rd  = '0;
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_rd  = wb_rd[i*REG_IDX_W +: REG_IDX_W];
        sel_val = wb_value[i*XLEN +: XLEN];
      end
    end
  end

  assign issue_ready = !(busy_q[issue_rs1] || busy_q[issue_rs2] ||
                         (issue_rd_write && busy_q[issue_rd]));
  assign stall_out   = issue_valid && !issue_ready;
  assign set_en      = issue_valid && issue_ready && issue_rd_write && (issue_rd != '0);

  // Clear of the register being written this cycle, then set from issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q)   busy_d[rd_q]     = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_d  = gnt_valid && (sel_rd != '0);
    rd_d  = gnt_valid ? sel_rd : rd_q;
    val_d = gnt_valid ? sel_val : val_q;
    err_d = err_q || (gnt_valid && (sel_rd != '0) && !busy_q[sel_rd]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
      val_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      val_q  <= val_d;
      err_q  <= err_d;
    end
  end

  assign rd_write_out = wr_q;
  assign rd_out       = RD_PORT_W'(rd_q);
  assign rd_value_out = val_q;
  assign err_out      = err_q;
  assign idle_out     = (busy_q == '0);
endmodule
